// File: rtl/speed_bram_arbiter_if.sv
// speed_bram_arbiter_if: request, BRAM read-port and response bundle of the speed-profile BRAM arbiter.
interface speed_bram_arbiter_if #(
    parameter int N  = 4,
    parameter int AW = 9,
    parameter int DW = 16
);
    logic [N-1:0]    i_req;
    logic [N*AW-1:0] i_addr;
    logic            o_bram_en;
    logic [AW-1:0]   o_bram_addr;
    logic [DW-1:0]   i_bram_data;
    logic [N-1:0]    o_rsp_valid;
    logic [DW-1:0]   o_rsp_data;
    logic [N-1:0]    o_overrun;
    logic            o_busy;
    modport master (
        output i_req, i_addr, i_bram_data,
        input  o_bram_en, o_bram_addr, o_rsp_valid, o_rsp_data, o_overrun, o_busy
    );
    modport slave (
        input  i_req, i_addr, i_bram_data,
        output o_bram_en, o_bram_addr, o_rsp_valid, o_rsp_data, o_overrun, o_busy
    );
endinterface

// File: rtl/speed_bram_arbiter.sv
// speed_bram_arbiter: round-robin sharing of the speed-profile BRAM read port among motor channels,
// one pending read per channel, responses tagged one-hot in grant order.
module speed_bram_arbiter #(
    parameter int C_MOTOR_NBR        = 4,
    parameter int C_BRAM_ADDR_WIDTH  = 9,
    parameter int C_SPEED_DATA_WIDTH = 16,
    parameter int C_BRAM_LATENCY     = 2
) (
    input logic               clk,
    input logic               reset,
    speed_bram_arbiter_if.slave bus
);
    localparam int N   = C_MOTOR_NBR;
    localparam int AW  = C_BRAM_ADDR_WIDTH;
    localparam int LAT = C_BRAM_LATENCY;
    localparam int PW  = $clog2(N);
    logic [N-1:0]  pending, cand, grant;
    logic [AW-1:0] held [N];
    logic [PW-1:0] ptr, win, idx;
    logic          found, tag_busy;
    logic [AW-1:0] win_addr;
    logic [N-1:0]  tags [LAT+1];
    assign cand = pending | bus.i_req;
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
    assign grant    = found ? (N'(1) << win) : '0;
    assign win_addr = pending[win] ? held[win] : bus.i_addr[win*AW +: AW];
    // tags[0] lines up with o_bram_en; tags[LAT] lines up with valid BRAM data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            ptr <= '0;
            bus.o_bram_en <= 1'b0;
            bus.o_bram_addr <= '0;
            bus.o_overrun <= '0;
            bus.o_rsp_valid <= '0;
            bus.o_rsp_data <= '0;
            for (int k = 0; k < N; k++) held[k] <= '0;
            for (int s = 0; s <= LAT; s++) tags[s] <= '0;
        end else begin
            pending <= cand & ~grant;
            bus.o_overrun <= bus.i_req & pending;
            bus.o_bram_en <= found;
            if (found) begin
                bus.o_bram_addr <= win_addr;
                ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
            end
            for (int k = 0; k < N; k++)
                if (bus.i_req[k] && !pending[k] && !grant[k]) held[k] <= bus.i_addr[k*AW +: AW];
            tags[0] <= grant;
            for (int s = 1; s <= LAT; s++) tags[s] <= tags[s-1];
            bus.o_rsp_valid <= tags[LAT];
            if (|tags[LAT]) bus.o_rsp_data <= bus.i_bram_data;
        end
    end
    always_comb begin
        tag_busy = 1'b0;
        for (int s = 0; s <= LAT; s++) tag_busy = tag_busy | (|tags[s]);
    end
    assign bus.o_busy = (|cand) | bus.o_bram_en | tag_busy | (|bus.o_rsp_valid);
endmodule
